// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

    localparam int          IF_ADDR_W        = 32;
    localparam int          IF_DATA_W        = 32;
    localparam int          DEPTH_DEFAULT    = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetched {pc, instr} entries with a registered head copy,
// so the head is available straight from flops with no read mux on the output.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output logic                     head_valid,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             CW       = $clog2(DEPTH) + 1;
    localparam int             PW       = $clog2(DEPTH);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0]  PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]  PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    fetch_entry_t  mem_r [DEPTH];
    fetch_entry_t  head_r;
    fetch_entry_t  head_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] rd_nxt_s;
    logic [PW-1:0] rd_inc_s;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] wr_nxt_s;
    logic          push_s;
    logic          pop_s;

    assign pop_s      = pop && (count_r != CNT_ZERO);
    assign push_s     = push && ((count_r != CNT_FULL) || pop_s);
    assign rd_inc_s   = rd_ptr_r + PTR_ONE;
    assign head_valid = (count_r != CNT_ZERO);
    assign head       = head_r;
    assign count      = count_r;

    // Next pointers, occupancy and head copy; the head reloads from the
    // incoming entry when it lands in an empty (or emptying) queue.
    always_comb begin
        count_nxt_s = count_r;
        rd_nxt_s    = rd_ptr_r;
        wr_nxt_s    = wr_ptr_r;
        head_nxt_s  = head_r;
        if (clear) begin
            count_nxt_s = CNT_ZERO;
            rd_nxt_s    = PTR_ZERO;
            wr_nxt_s    = PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_nxt_s = rd_inc_s;
            end else begin
                rd_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10: begin
                    count_nxt_s = count_r + CNT_ONE;
                    if (count_r == CNT_ZERO) begin
                        head_nxt_s = push_entry;
                    end else begin
                        head_nxt_s = head_r;
                    end
                end
                2'b01: begin
                    count_nxt_s = count_r - CNT_ONE;
                    if (count_r > CNT_ONE) begin
                        head_nxt_s = mem_r[rd_inc_s];
                    end else begin
                        head_nxt_s = head_r;
                    end
                end
                2'b11: begin
                    count_nxt_s = count_r;
                    if (count_r == CNT_ONE) begin
                        head_nxt_s = push_entry;
                    end else begin
                        head_nxt_s = mem_r[rd_inc_s];
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                    head_nxt_s  = head_r;
                end
            endcase
        end
    end

    // Control state and head copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r  <= CNT_ZERO;
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            head_r   <= '{pc: {IF_ADDR_W{1'b0}}, instr: {IF_DATA_W{1'b0}}};
        end else begin
            count_r  <= count_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            wr_ptr_r <= wr_nxt_s;
            head_r   <= head_nxt_s;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: {IF_ADDR_W{1'b0}}, instr: {IF_DATA_W{1'b0}}};
            end
        end else if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetching, in-order
// response capture and jump redirect with stale-response discard.
module inst_fetch_queue
    import if_pkg::*;
#(
    parameter int                 ADDR_W   = IF_ADDR_W,
    parameter int                 DATA_W   = IF_DATA_W,
    parameter int                 DEPTH    = DEPTH_DEFAULT,
    parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int             CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]    CREDIT_MAX = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] fetch_pc_nxt_s;
    logic [ADDR_W-1:0] resp_pc_r;
    logic [ADDR_W-1:0] resp_pc_nxt_s;
    logic [CW-1:0]     outstanding_r;
    logic [CW-1:0]     outstanding_nxt_s;
    logic [CW-1:0]     discard_r;
    logic [CW-1:0]     discard_nxt_s;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     resp_dec_s;
    logic              credit_s;
    logic              issue_s;
    logic              resp_s;
    logic              push_s;
    logic              pop_s;
    logic              head_valid_s;
    fetch_entry_t      head_s;
    fetch_entry_t      push_entry_s;

    // Every queued entry and every owed response holds one slot of credit,
    // which is what keeps the queue from overflowing.
    assign credit_s   = ({1'b0, count_s} + {1'b0, outstanding_r}) < CREDIT_MAX;
    assign imem_req   = rst && !jump_flag && credit_s;
    assign imem_addr  = fetch_pc_r;
    assign issue_s    = imem_req && imem_ready;
    assign resp_s     = imem_rvalid && (outstanding_r != CNT_ZERO);
    assign resp_dec_s = resp_s ? CNT_ONE : CNT_ZERO;
    assign push_s     = resp_s && (discard_r == CNT_ZERO) && !jump_flag;
    assign pop_s      = head_valid_s && instr_ready && !jump_flag;

    assign push_entry_s = '{pc: resp_pc_r, instr: imem_rdata};
    assign instr_valid  = head_valid_s;
    assign instr        = head_s.instr;
    assign instr_pc     = head_s.pc;

    // Next PCs and response bookkeeping; a jump overrides everything else.
    always_comb begin
        fetch_pc_nxt_s    = fetch_pc_r;
        resp_pc_nxt_s     = resp_pc_r;
        outstanding_nxt_s = outstanding_r;
        discard_nxt_s     = discard_r;
        case ({issue_s, resp_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
            default: outstanding_nxt_s = outstanding_r;
        endcase
        if (jump_flag) begin
            fetch_pc_nxt_s = jump_addr & ALIGN_MASK;
            resp_pc_nxt_s  = jump_addr & ALIGN_MASK;
            discard_nxt_s  = outstanding_r - resp_dec_s;
        end else begin
            if (issue_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (push_s) begin
                resp_pc_nxt_s = resp_pc_r + PC_STEP;
            end else begin
                resp_pc_nxt_s = resp_pc_r;
            end
            if (resp_s && (discard_r != CNT_ZERO)) begin
                discard_nxt_s = discard_r - CNT_ONE;
            end else begin
                discard_nxt_s = discard_r;
            end
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            discard_r     <= CNT_ZERO;
        end else begin
            fetch_pc_r    <= fetch_pc_nxt_s;
            resp_pc_r     <= resp_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (jump_flag),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head       (head_s),
        .count      (count_s)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order variable-latency memory.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .jump_flag   (jump_flag),
        .jump_addr   (jump_addr),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    typedef struct {
        bit          rst_first;
        int          lat;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_instr[$];
    logic        samp_acc, samp_rv, samp_pop;
    logic [31:0] samp_addr, samp_pc, samp_instr;
    vec_t        vecs[15];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive this cycle's memory response, let logic settle, sample handshakes.
    task automatic settle();
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(pend_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        samp_acc   = imem_req && imem_ready;
        samp_addr  = imem_addr;
        samp_rv    = imem_rvalid;
        samp_pop   = instr_valid && instr_ready && !jump_flag;
        samp_pc    = instr_pc;
        samp_instr = instr;
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (samp_rv) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (samp_acc) begin
            pend_addr.push_back(samp_addr);
            pend_due.push_back(cyc + lat);
        end
        if (samp_pop) begin
            log_pc.push_back(samp_pc);
            log_instr.push_back(samp_instr);
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        settle();
        edge_step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " imem_req"},    {31'h0, imem_req},    32'h0);
        chk({tag, " imem_addr"},   imem_addr,            32'h0);
        chk({tag, " instr_valid"}, {31'h0, instr_valid}, 32'h0);
        chk({tag, " instr"},       instr,                32'h0);
        chk({tag, " instr_pc"},    instr_pc,             32'h0);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        jump_flag   = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        imem_ready  = 1'b1;
        pend_addr.delete();
        pend_due.delete();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        cyc = 0;
        log_pc.delete();
        log_instr.delete();
    endtask

    // Run with decode always ready until n entries are consumed; they must be
    // consecutive words from base with matching data.
    task automatic drain_check(input string name, input logic [31:0] base, input int n, input int budget);
        int k = 0;
        instr_ready = 1'b1;
        imem_ready  = 1'b1;
        jump_flag   = 1'b0;
        while (log_pc.size() < n && k < budget) begin
            step();
            k++;
        end
        if (log_pc.size() < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: got %0d entries, expected %0d", name, log_pc.size(), n);
        end
        for (int i = 0; i < n && i < log_pc.size(); i++) begin
            chk({name, " pc"},    log_pc[i],    base + 32'(4 * i));
            chk({name, " instr"}, log_instr[i], word(base + 32'(4 * i)));
        end
    endtask

    initial begin
        // Back-to-back fetching with 1-cycle memory and decode always ready.
        vecs[0]  = '{1'b1, 1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b0, 1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        // Decode stalled: credit stops after four fetches, one pop frees one.
        vecs[6]  = '{1'b1, 1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[7]  = '{1'b0, 1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[8]  = '{1'b0, 1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[9]  = '{1'b0, 1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
        vecs[10] = '{1'b0, 1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[11] = '{1'b0, 1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[12] = '{1'b0, 1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
        vecs[13] = '{1'b0, 1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h04};
        vecs[14] = '{1'b0, 1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h04};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst_first) do_reset();
            lat         = vecs[i].lat;
            instr_ready = vecs[i].ready;
            settle();
            chk($sformatf("vec%0d imem_req", i),    {31'h0, imem_req},    {31'h0, vecs[i].exp_req});
            chk($sformatf("vec%0d imem_addr", i),   imem_addr,            vecs[i].exp_addr);
            chk($sformatf("vec%0d instr_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d instr", i),    instr,    word(vecs[i].exp_pc));
            end
            edge_step();
        end
        log_pc.delete();
        log_instr.delete();
        drain_check("stall drain", 32'h04, 6, 40);

        // Jump with three stale fetches in flight on a 4-cycle memory.
        do_reset();
        lat = 4;
        instr_ready = 1'b1;
        repeat (3) step();
        jump_flag = 1'b1;
        jump_addr = 32'h100;
        settle();
        chk("stale jump imem_req", {31'h0, imem_req}, 32'h0);
        log_pc.delete();
        log_instr.delete();
        edge_step();
        jump_flag = 1'b0;
        settle();
        chk("stale jump next addr",  imem_addr,            32'h100);
        chk("stale jump next req",   {31'h0, imem_req},    32'h1);
        chk("stale jump next valid", {31'h0, instr_valid}, 32'h0);
        edge_step();
        drain_check("stale discard", 32'h100, 4, 60);

        // Jump coinciding with a response and a pop.
        do_reset();
        lat = 1;
        instr_ready = 1'b1;
        repeat (3) step();
        jump_flag = 1'b1;
        jump_addr = 32'h100;
        settle();
        chk("jump+pop valid before", {31'h0, instr_valid}, 32'h1);
        chk("jump+pop imem_req",     {31'h0, imem_req},    32'h0);
        log_pc.delete();
        log_instr.delete();
        edge_step();
        jump_flag = 1'b0;
        settle();
        chk("jump+pop queue empty", {31'h0, instr_valid}, 32'h0);
        chk("jump+pop next addr",   imem_addr,            32'h100);
        chk("jump+pop next req",    {31'h0, imem_req},    32'h1);
        edge_step();
        drain_check("jump+pop drain", 32'h100, 3, 40);

        // Unaligned target, then two back-to-back jumps.
        do_reset();
        lat = 2;
        instr_ready = 1'b1;
        repeat (2) step();
        jump_flag = 1'b1;
        jump_addr = 32'h203;
        step();
        jump_flag = 1'b0;
        settle();
        chk("align addr", imem_addr, 32'h200);
        edge_step();
        step();
        jump_flag = 1'b1;
        jump_addr = 32'h40;
        step();
        jump_addr = 32'h80;
        settle();
        log_pc.delete();
        log_instr.delete();
        edge_step();
        jump_flag = 1'b0;
        settle();
        chk("double jump empty", {31'h0, instr_valid}, 32'h0);
        chk("double jump addr",  imem_addr,            32'h80);
        edge_step();
        drain_check("double jump", 32'h80, 5, 60);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        lat = 2;
        instr_ready = 1'b1;
        repeat (6) step();
        rst = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        do_reset();
        drain_check("after reset", 32'h00, 4, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
